// File: rtl/pdm_array_sequencer.sv
// Strobe scheduler and snapshot serialiser for a bank of PDM CIC decimators.
// Define PDM_SEQ_FALL_EN to stream falling-edge (F) samples interleaved with rising-edge (R) ones.
module pdm_array_sequencer #(
    parameter int p_width    = 8,
    parameter int p_channels = 4,
    parameter int p_decim    = 64,
    parameter int p_capdly   = 2,
    parameter int p_idxw     = 3
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_enable,
    output logic                           o_strobe,
    input  logic [p_channels*p_width-1:0]  i_dataR,
    input  logic [p_channels*p_width-1:0]  i_dataF,
    output logic [p_width-1:0]             o_sample,
    output logic [p_idxw-1:0]              o_chan,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_frame_start,
    output logic                           o_overrun,
    input  logic                           i_clear_overrun
);

    localparam int CW = $clog2(p_decim);
    localparam int DW = $clog2(p_capdly) + 1;
`ifdef PDM_SEQ_FALL_EN
    localparam int N = 2 * p_channels;
`else
    localparam int N = p_channels;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [DW-1:0]                   dly_q, dly_d;
    logic                            strobe_q, strobe_d;
    logic [p_channels*p_width-1:0]   snap_r_q, snap_r_d;
`ifdef PDM_SEQ_FALL_EN
    logic [p_channels*p_width-1:0]   snap_f_q, snap_f_d;
`else
    logic                            unused_dataf;
    assign unused_dataf = ^i_dataF;
`endif
    logic [p_width-1:0]              sample_q, sample_d, nxt_sample;
    logic [p_idxw-1:0]               chan_q, chan_d, nxt_idx;
    logic                            valid_q, valid_d;
    logic                            fs_q, fs_d;
    logic                            overrun_q, overrun_d;

    // Sample for the following index, taken from the snapshot registers.
    always_comb begin
        nxt_idx    = chan_q + 1'b1;
        nxt_sample = '0;
        for (int c = 0; c < p_channels; c++) begin
`ifdef PDM_SEQ_FALL_EN
            if ((nxt_idx >> 1) == p_idxw'(c))
                nxt_sample = nxt_idx[0] ? snap_f_q[c*p_width +: p_width]
                                        : snap_r_q[c*p_width +: p_width];
`else
            if (nxt_idx == p_idxw'(c))
                nxt_sample = snap_r_q[c*p_width +: p_width];
`endif
        end
    end

    always_comb begin
        cnt_d = '0;
        if (i_enable)
            cnt_d = (cnt_q == CW'(p_decim - 1)) ? '0 : cnt_q + 1'b1;
        // Registered strobe: decided one count early so it lands on p_decim-1.
        strobe_d = i_enable && (cnt_q == CW'(p_decim - 2));

        state_d  = state_q;
        dly_d    = dly_q;
        snap_r_d = snap_r_q;
`ifdef PDM_SEQ_FALL_EN
        snap_f_d = snap_f_q;
`endif
        sample_d = sample_q;
        chan_d   = chan_q;
        valid_d  = valid_q;
        fs_d     = fs_q;

        case (state_q)
            S_IDLE: begin
                if (strobe_q) begin
                    state_d = S_WAIT;
                    dly_d   = DW'(p_capdly - 1);
                end
            end
            S_WAIT: begin
                if (dly_q == '0) begin
                    snap_r_d = i_dataR;
`ifdef PDM_SEQ_FALL_EN
                    snap_f_d = i_dataF;
`endif
                    sample_d = i_dataR[p_width-1:0];
                    chan_d   = '0;
                    valid_d  = 1'b1;
                    fs_d     = 1'b1;
                    state_d  = S_SEND;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            S_SEND: begin
                if (i_ready) begin
                    fs_d = 1'b0;
                    if (chan_q == p_idxw'(N - 1)) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        chan_d   = nxt_idx;
                        sample_d = nxt_sample;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe while busy is dropped; setting beats a simultaneous clear.
        overrun_d = overrun_q;
        if (strobe_q && (state_q != S_IDLE))
            overrun_d = 1'b1;
        else if (i_clear_overrun)
            overrun_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dly_q     <= '0;
            strobe_q  <= 1'b0;
            snap_r_q  <= '0;
`ifdef PDM_SEQ_FALL_EN
            snap_f_q  <= '0;
`endif
            sample_q  <= '0;
            chan_q    <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            strobe_q  <= strobe_d;
            snap_r_q  <= snap_r_d;
`ifdef PDM_SEQ_FALL_EN
            snap_f_q  <= snap_f_d;
`endif
            sample_q  <= sample_d;
            chan_q    <= chan_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_strobe      = strobe_q;
    assign o_sample      = sample_q;
    assign o_chan        = chan_q;
    assign o_valid       = valid_q;
    assign o_frame_start = fs_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_pdm_array_sequencer.sv
// Directed bench for pdm_array_sequencer: strobe schedule, frame order, backpressure, overrun, reset.
module tb_pdm_array_sequencer;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int D  = 16;
    localparam int CD = 2;
    localparam int IW = 2;
`ifdef PDM_SEQ_FALL_EN
    localparam int N = 2 * C;
`else
    localparam int N = C;
`endif

    logic           clk = 1'b0;
    logic           i_reset_n, i_enable, i_ready, i_clear_overrun;
    logic [C*W-1:0] i_dataR, i_dataF;
    logic           o_strobe, o_valid, o_frame_start, o_overrun;
    logic [W-1:0]   o_sample;
    logic [IW-1:0]  o_chan;

    logic [C*W-1:0] base_r, base_f;
    logic [W-1:0]   exp_s [4];
    int             tests = 0;
    int             fails = 0;
    int             n;

    always #5 clk = ~clk;

    pdm_array_sequencer #(
        .p_width(W), .p_channels(C), .p_decim(D), .p_capdly(CD), .p_idxw(IW)
    ) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .o_strobe(o_strobe),
        .i_dataR(i_dataR), .i_dataF(i_dataF), .o_sample(o_sample), .o_chan(o_chan),
        .o_valid(o_valid), .i_ready(i_ready), .o_frame_start(o_frame_start),
        .o_overrun(o_overrun), .i_clear_overrun(i_clear_overrun)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_strobe(input int maxc, output int cnt);
        cnt = 0;
        do begin
            step;
            cnt++;
        end while (o_strobe !== 1'b1 && cnt < maxc);
        chk("strobe_seen", o_strobe, 1);
    endtask

    // Called just after the strobe is observed (cycle E). Inputs are scrambled
    // after the snapshot so the stream must come from the captured values.
    task automatic frame_check(input int bp_at, input int bp_len, input int clr_at);
        step; chk("strobe_width", o_strobe, 0);
        step; chk("wait_valid", o_valid, 0);
        step;
        i_dataR = ~base_r;
        i_dataF = ~base_f;
        for (int i = 0; i < N; i++) begin
            chk("valid", o_valid, 1);
            chk("sample", o_sample, exp_s[i]);
            chk("chan", o_chan, i);
            chk("frame_start", o_frame_start, (i == 0));
            if (i == bp_at) begin
                i_ready = 1'b0;
                for (int j = 1; j <= bp_len; j++) begin
                    if (j == clr_at) i_clear_overrun = 1'b1;
                    step;
                    i_clear_overrun = 1'b0;
                    chk("bp_valid", o_valid, 1);
                    chk("bp_sample", o_sample, exp_s[i]);
                    chk("bp_chan", o_chan, i);
                    chk("bp_strobe", o_strobe, (3 + i + j == D));
                end
                i_ready = 1'b1;
            end
            step;
        end
        chk("valid_end", o_valid, 0);
        i_dataR = base_r;
        i_dataF = base_f;
    endtask

    initial begin
        base_r = 16'h2211;
        base_f = 16'h4433;
`ifdef PDM_SEQ_FALL_EN
        exp_s[0] = 8'h11; exp_s[1] = 8'h33; exp_s[2] = 8'h22; exp_s[3] = 8'h44;
`else
        exp_s[0] = 8'h11; exp_s[1] = 8'h22; exp_s[2] = 8'h00; exp_s[3] = 8'h00;
`endif
        i_reset_n = 1'b0; i_enable = 1'b1; i_ready = 1'b1; i_clear_overrun = 1'b0;
        i_dataR = base_r; i_dataF = base_f;

        repeat (3) step;
        chk("rst_strobe", o_strobe, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_sample", o_sample, 0);
        chk("rst_chan", o_chan, 0);
        chk("rst_fs", o_frame_start, 0);
        chk("rst_overrun", o_overrun, 0);

        i_reset_n = 1'b1;
        for (int k = 1; k <= D - 1; k++) begin
            step;
            chk("startup_strobe", o_strobe, (k == D - 1));
        end

        frame_check(-1, 0, 0);
        chk("basic_overrun", o_overrun, 0);

        wait_strobe(40, n);
        chk("strobe_period", n, D - 3 - N);
        frame_check(1, 5, 0);
        chk("bp_overrun", o_overrun, 0);

        wait_strobe(40, n);
        frame_check(1, 20, 0);
        chk("overrun_set", o_overrun, 1);

        i_clear_overrun = 1'b1;
        step;
        i_clear_overrun = 1'b0;
        chk("overrun_clear", o_overrun, 0);

        wait_strobe(40, n);
        frame_check(1, 20, 13);
        chk("overrun_set_wins", o_overrun, 1);

        wait_strobe(40, n);
        repeat (3) step;
        chk("mid_valid", o_valid, 1);
        i_reset_n = 1'b0;
        step;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_sample", o_sample, 0);
        chk("mid_rst_overrun", o_overrun, 0);
        i_reset_n = 1'b1;
        for (int k = 1; k <= D - 1; k++) begin
            step;
            chk("restart_strobe", o_strobe, (k == D - 1));
        end
        frame_check(-1, 0, 0);

        i_enable = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step;
            chk("disabled_strobe", o_strobe, 0);
        end
        chk("disabled_valid", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_array_sequencer.md
# pdm_array_sequencer

Controller for a bank of PDM microphone CIC decimators. Generates the shared decimation strobe on a fixed schedule and snapshots every decimator's rising- and falling-edge outputs after each strobe. Serialises the snapshot into one sample stream with a valid/ready handshake. Sits between the decimator array and the downstream beamforming/capture logic, and flags frames it had to drop.

## Interface
- p_width, 8 — bits per decimated sample
- p_channels, 4 — microphone data lines; each line carries one rising-edge (R) and one falling-edge (F) sample
- p_decim, 64 — i_clk cycles between strobes; must be ≥ 4
- p_capdly, 2 — cycles from strobe to snapshot, covering decimator output latency; must satisfy 1 ≤ p_capdly ≤ p_decim-2
- p_idxw, 3 — o_chan width; must satisfy 2^p_idxw ≥ 2·p_channels
- i_clk  in  1  — single clock for the whole block
- i_reset_n  in  1  — reset, synchronous, active-low
- i_enable  in  1  — run the strobe schedule
- o_strobe  out  1  — one-cycle decimation strobe to all decimators
- i_dataR  in  p_channels·p_width  — R outputs; channel c occupies bits [c·p_width +: p_width]
- i_dataF  in  p_channels·p_width  — F outputs; same packing as i_dataR
- o_sample  out  p_width  — serialised sample
- o_chan  out  p_idxw  — stream index of o_sample
- o_valid  out  1  — o_sample/o_chan valid
- i_ready  in  1  — downstream accepts the current sample
- o_frame_start  out  1  — high with the first sample (index 0) of each frame
- o_overrun  out  1  — sticky dropped-frame flag
- i_clear_overrun  in  1  — clears o_overrun

## Operation
- **Strobe counter**
  - Counts 0 … p_decim-1 and wraps.
  - o_strobe = 1 for one cycle when the counter equals p_decim-1 and i_enable = 1.
  - i_enable = 0 holds the counter at 0 and emits no strobes. A frame already in progress still completes.
- **FSM states:** IDLE, WAIT, SEND.
  - IDLE → WAIT on o_strobe. A delay counter loads p_capdly-1.
  - WAIT counts down. At 0, it snapshots i_dataR and i_dataF into internal registers, sets the index to 0, and moves to SEND.
  - In SEND, o_valid = 1. The sample transfers when o_valid & i_ready are both high. The index then increments.
  - The transfer of the last index returns the FSM to IDLE.
- **Stream order:** index k carries channel k>>1. Even k is the R sample, odd k is the F sample (see Configuration). o_chan = k.
- **Handshake:** while o_valid & !i_ready, o_sample, o_chan and o_frame_start hold stable. o_valid never drops without a transfer, except on reset.
- **Overrun**
  - If o_strobe fires while the FSM is in WAIT or SEND, the strobe still goes to the decimators and the current frame continues unchanged.
  - The new frame is not captured, and o_overrun is set.
  - i_clear_overrun clears o_overrun. If a set and a clear happen in the same cycle, the set wins.
- **Reset:** all outputs are 0, the counter is 0 and the FSM is in IDLE. Reset mid-frame discards the frame; o_valid = 0 on the cycle after i_reset_n is sampled low.

## Timing
- **Start-up:** after reset release with i_enable = 1, the first o_strobe is on the p_decim-th cycle.
- **Frame timing:** with o_strobe at cycle t:
  - snapshot at t+p_capdly;
  - first o_valid at t+p_capdly+1;
  - with i_ready held high, one sample per cycle, so the last sample of an N-sample frame is at t+p_capdly+N.
- **Overrun-free operation** requires p_decim ≥ p_capdly+N+1 with i_ready continuously high. A shorter p_decim overruns on every other frame by design.
- All outputs are registered. There is no combinational path from i_ready to o_valid.

## Configuration
- **PDM_SEQ_FALL_EN defined:** frames have N = 2·p_channels samples, interleaved R/F as above.
- **PDM_SEQ_FALL_EN undefined:**
  - frames have N = p_channels samples, R only;
  - index k = channel k;
  - i_dataF is ignored and no F snapshot registers are built.

## Test plan
Defaults for all scenarios: p_channels=2, p_decim=16, p_capdly=2, p_width=8; PDM_SEQ_FALL_EN defined unless stated.
- **Reset:** hold i_reset_n=0, enable=1 → all outputs 0. Release → first o_strobe on cycle 16, pulse width 1, repeating every 16 cycles.
- **Basic frame:** i_dataR={8'h22,8'h11}, i_dataF={8'h44,8'h33}, i_ready=1 → from strobe+3, samples 11,33,22,44 with o_chan 0,1,2,3 on consecutive cycles; o_frame_start only with 11; o_valid drops after 44.
- **Backpressure:** i_ready=0 for 5 cycles while sample 33 is presented → 33 and o_chan=1 held stable, o_valid stays 1; 22 follows one cycle after i_ready returns to 1.
- **Overrun:** i_ready=0 for 20 cycles mid-frame → next strobe still pulses, o_overrun=1, stream resumes with the remaining first-frame samples. i_clear_overrun alone → 0. Clear coincident with a new overrun → stays 1.
- **Macro undefined:** basic-frame stimulus → samples 11,22 with o_chan 0,1; o_valid drops after 22.
- **Reset mid-frame:** i_reset_n=0 during SEND → o_valid=0 next cycle. After release, the next strobe arrives at cycle 16 and the frame starts at index 0.
